// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
// Holds the FSM state encoding, the stall-counter width and the index-width helper.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int STALL_CNT_W = 16;

   // A 1-bit index is still needed when there is only a single requester
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
// Latency: purely combinational, zero cycles.
// No flow control; o_next holds i_last when no request is set.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_last,
   output logic [IW-1:0]   o_next,
   output logic            o_any
);

   logic w_found;

   // i_last itself is scanned last, which gives the previous owner the lowest priority
   always_comb begin
      w_found = 1'b0;
      o_next  = i_last;
      for (int i = 1; i <= NREQ; i++) begin
         if (!w_found && i_req[(int'(i_last) + i) % NREQ]) begin
            w_found = 1'b1;
            o_next  = IW'((int'(i_last) + i) % NREQ);
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port; optional stall counter under ARB_STALL_STATS_EN.
// Latency: 1 cycle from request to the first write, then one word per cycle for up to MAX_BURST words.
// Backpressure: full_i holds the owner with no write and no ack; the burst count is frozen until full_i drops.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NREQ      = 4,
   parameter  int DATALEN   = 8,
   parameter  int MAX_BURST = 4,
   localparam int IW        = idx_w(NREQ)
) (
   input  logic                    wclk,
   input  logic                    wrst_n,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*DATALEN-1:0] data_i,
   output logic [NREQ-1:0]         ack_o,
   input  logic                    full_i,
   output logic                    winc_o,
   output logic [DATALEN-1:0]      wdata_o,
   output logic [IW-1:0]           owner_o,
   output logic                    busy_o
`ifdef ARB_STALL_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0]  stall_cnt_o
`endif
);

   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     w_owner_nxt;
   logic [BW-1:0]     r_burst_cnt;
   logic [BW-1:0]     w_cnt_nxt;
   logic [IW-1:0]     w_pick;
   logic              w_any_req;
   logic              w_own_req;
   logic              w_grant;
   logic              w_winc;
   logic [NREQ-1:0]   w_ack;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .i_req  (req_i),
      .i_last (r_owner),
      .o_next (w_pick),
      .o_any  (w_any_req)
   );

   assign w_own_req = req_i[r_owner];
   assign w_grant   = (r_state == GRANT);
   assign w_winc    = w_grant & w_own_req & ~full_i;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state     <= IDLE;
         r_owner     <= IW'(NREQ - 1);
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_burst_cnt;
      w_ack       = '0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt = GRANT;
               w_owner_nxt = w_pick;
               w_cnt_nxt   = '0;
            end
         end
         GRANT: begin
            w_ack[r_owner] = w_winc;
            // A withdrawn request ends the grant even if the FIFO is full
            if (!w_own_req) begin
               w_state_nxt = IDLE;
            end else if (w_winc) begin
               w_cnt_nxt = r_burst_cnt + BW'(1);
               if (r_burst_cnt == BW'(MAX_BURST - 1)) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign winc_o  = w_winc;
   assign ack_o   = w_ack;
   assign busy_o  = w_grant;
   assign owner_o = r_owner;
   assign wdata_o = w_grant ? data_i[r_owner*DATALEN +: DATALEN] : '0;

`ifdef ARB_STALL_STATS_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_stall_cnt <= '0;
      end else if (w_grant && w_own_req && full_i && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter with NREQ=4, DATALEN=8, MAX_BURST=4.
// Requester k presents word {k, seq[k]}; seq[k] advances on each of its acks.
module tb_fifo_wr_arbiter;

   logic        wclk;
   logic        wrst_n;
   logic [3:0]  req_i;
   logic [31:0] data_i;
   logic [3:0]  ack_o;
   logic        full_i;
   logic        winc_o;
   logic [7:0]  wdata_o;
   logic [1:0]  owner_o;
   logic        busy_o;
`ifdef ARB_STALL_STATS_EN
   logic [15:0] stall_cnt_o;
`endif

   int          n_checks;
   int          n_errors;
   logic [3:0]  seq [4];

   fifo_wr_arbiter #(
      .NREQ      (4),
      .DATALEN   (8),
      .MAX_BURST (4)
   ) dut (
      .wclk    (wclk),
      .wrst_n  (wrst_n),
      .req_i   (req_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .full_i  (full_i),
      .winc_o  (winc_o),
      .wdata_o (wdata_o),
      .owner_o (owner_o),
      .busy_o  (busy_o)
`ifdef ARB_STALL_STATS_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_data();
      for (int k = 0; k < 4; k++) data_i[k*8 +: 8] = {4'(k), seq[k]};
   endtask

   task automatic clr_seq();
      for (int k = 0; k < 4; k++) seq[k] = 4'd0;
   endtask

   // Called at posedge+1: apply inputs, sample at negedge, return at next posedge+1
   task automatic cyc(input string tag, input logic [3:0] req, input logic full,
                      input logic e_busy, input logic [3:0] e_ack,
                      input logic [1:0] e_own, input logic [7:0] e_wd);
      req_i  = req;
      full_i = full;
      build_data();
      @(negedge wclk);
      chk({tag, ".busy"},  busy_o,  e_busy);
      chk({tag, ".ack"},   ack_o,   e_ack);
      chk({tag, ".winc"},  winc_o,  |e_ack);
      chk({tag, ".owner"}, owner_o, e_own);
      chk({tag, ".wdata"}, wdata_o, e_wd);
      for (int k = 0; k < 4; k++) if (ack_o[k]) seq[k] = seq[k] + 4'd1;
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst_n = 1'b0;
      req_i  = 4'b0000;
      full_i = 1'b0;
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
      clr_seq();
   endtask

   initial begin
      int wait_w [4];
      int max_wait;
      n_checks = 0;
      n_errors = 0;
      clr_seq();
      wrst_n = 1'b0;
      req_i  = 4'b1111;
      full_i = 1'b0;
      build_data();

      // Reset state with all requests held
      @(posedge wclk);
      @(negedge wclk);
      chk("rst.busy",  busy_o,  0);
      chk("rst.winc",  winc_o,  0);
      chk("rst.ack",   ack_o,   0);
      chk("rst.owner", owner_o, 3);
      chk("rst.wdata", wdata_o, 0);
`ifdef ARB_STALL_STATS_EN
      chk("rst.stall", stall_cnt_o, 0);
`endif
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;

      // t1: requester 0 first, full burst of 4, then requester 1
      cyc("t1.c1", 4'b1111, 0, 0, 4'b0000, 3, 8'h00);
      cyc("t1.c2", 4'b1111, 0, 1, 4'b0001, 0, 8'h00);
      cyc("t1.c3", 4'b1111, 0, 1, 4'b0001, 0, 8'h01);
      cyc("t1.c4", 4'b1111, 0, 1, 4'b0001, 0, 8'h02);
      cyc("t1.c5", 4'b1111, 0, 1, 4'b0001, 0, 8'h03);
      cyc("t1.c6", 4'b1111, 0, 0, 4'b0000, 0, 8'h00);
      cyc("t1.c7", 4'b1111, 0, 1, 4'b0010, 1, 8'h10);
      cyc("t1.c8", 4'b0000, 0, 1, 4'b0000, 1, 8'h11);
      cyc("t1.c9", 4'b0000, 0, 0, 4'b0000, 1, 8'h00);

      // t2: requesters 1 and 3 alternate in bursts of 4 with one idle cycle between
      do_reset();
      cyc("t2.i0", 4'b1010, 0, 0, 4'b0000, 3, 8'h00);
      for (int i = 0; i < 4; i++) cyc("t2.r1a", 4'b1010, 0, 1, 4'b0010, 1, 8'h10 + 8'(i));
      cyc("t2.i1", 4'b1010, 0, 0, 4'b0000, 1, 8'h00);
      for (int i = 0; i < 4; i++) cyc("t2.r3", 4'b1010, 0, 1, 4'b1000, 3, 8'h30 + 8'(i));
      cyc("t2.i2", 4'b1010, 0, 0, 4'b0000, 3, 8'h00);
      for (int i = 0; i < 4; i++) cyc("t2.r1b", 4'b1010, 0, 1, 4'b0010, 1, 8'h14 + 8'(i));
      cyc("t2.i3", 4'b0000, 0, 0, 4'b0000, 1, 8'h00);

      // t3: owner 2 stalled by full for 5 cycles after 2 words
      do_reset();
      cyc("t3.i0", 4'b0100, 0, 0, 4'b0000, 3, 8'h00);
      cyc("t3.w0", 4'b0100, 0, 1, 4'b0100, 2, 8'h20);
      cyc("t3.w1", 4'b0100, 0, 1, 4'b0100, 2, 8'h21);
      for (int i = 0; i < 5; i++) cyc("t3.full", 4'b0100, 1, 1, 4'b0000, 2, 8'h22);
`ifdef ARB_STALL_STATS_EN
      chk("t3.stall", stall_cnt_o, 5);
`endif
      cyc("t3.w2", 4'b0100, 0, 1, 4'b0100, 2, 8'h22);
      cyc("t3.w3", 4'b0100, 0, 1, 4'b0100, 2, 8'h23);
      cyc("t3.i1", 4'b0000, 0, 0, 4'b0000, 2, 8'h00);

      // t4: owner 0 withdraws after 1 word; owner 3 then gets a fresh burst of 4
      do_reset();
      cyc("t4.i0", 4'b1001, 0, 0, 4'b0000, 3, 8'h00);
      cyc("t4.w0", 4'b1001, 0, 1, 4'b0001, 0, 8'h00);
      cyc("t4.drop", 4'b1000, 0, 1, 4'b0000, 0, 8'h01);
      cyc("t4.i1", 4'b1000, 0, 0, 4'b0000, 0, 8'h00);
      for (int i = 0; i < 4; i++) cyc("t4.r3", 4'b1000, 0, 1, 4'b1000, 3, 8'h30 + 8'(i));
      cyc("t4.i2", 4'b0000, 0, 0, 4'b0000, 3, 8'h00);

      // t5: async reset on the 3rd word of a burst
      do_reset();
      cyc("t5.i0", 4'b0001, 0, 0, 4'b0000, 3, 8'h00);
      cyc("t5.w0", 4'b0001, 0, 1, 4'b0001, 0, 8'h00);
      cyc("t5.w1", 4'b0001, 0, 1, 4'b0001, 0, 8'h01);
      wrst_n = 1'b0;
      cyc("t5.rst", 4'b0001, 0, 0, 4'b0000, 3, 8'h00);
      wrst_n = 1'b1;
      cyc("t5.i1", 4'b0011, 0, 0, 4'b0000, 3, 8'h00);
      cyc("t5.w2", 4'b0011, 0, 1, 4'b0001, 0, 8'h02);
      cyc("t5.drop", 4'b0000, 0, 1, 4'b0000, 0, 8'h03);
      cyc("t5.i2", 4'b0000, 0, 0, 4'b0000, 0, 8'h00);

      // t6: random requests and full; word order, full safety and starvation bound
      do_reset();
      max_wait = 0;
      for (int k = 0; k < 4; k++) wait_w[k] = 0;
      req_i = 4'b0000;
      for (int c = 0; c < 1000; c++) begin
         full_i = ($urandom_range(3) == 0);
         build_data();
         @(negedge wclk);
         chk("rnd.full_wr", winc_o & full_i, 0);
         chk("rnd.idle_wr", winc_o & ~busy_o, 0);
         chk("rnd.ack_1hot", $onehot0(ack_o), 1);
         chk("rnd.winc_ack", winc_o, |ack_o);
         for (int k = 0; k < 4; k++) begin
            if (ack_o[k]) begin
               chk("rnd.order", wdata_o, {4'(k), seq[k]});
               if (wait_w[k] > max_wait) max_wait = wait_w[k];
               wait_w[k] = 0;
               seq[k]    = seq[k] + 4'd1;
               req_i[k]  = ($urandom_range(3) != 0);
            end else if (!req_i[k]) begin
               wait_w[k] = 0;
               req_i[k]  = ($urandom_range(1) == 1);
            end else if (|ack_o) begin
               wait_w[k]++;
            end
         end
         @(posedge wclk);
         #1;
      end
      chk("rnd.max_wait_ok", (max_wait <= 12), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
